// File: rtl/mips_mem_arbiter.sv
// Arbitrates one single-port unified memory between the MIPS fetch and data paths.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mips_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nx;
  logic              mem_req_nx, mem_we_nx, if_ack_nx, d_ack_nx;
  logic [BE_W-1:0]   mem_be_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx, if_rdata_nx, d_rdata_nx;
  logic              grant_d;

  // Data wins unless a waiting fetch has already been passed over STARVE_MAX times.
  assign grant_d = d_req && !(if_req && (starve_cnt == CNT_MAX));

  always_comb begin
    state_nx      = state;
    starve_cnt_nx = starve_cnt;
    mem_req_nx    = mem_req;
    mem_we_nx     = mem_we;
    mem_be_nx     = mem_be;
    mem_addr_nx   = mem_addr;
    mem_wdata_nx  = mem_wdata;
    if_ack_nx     = 1'b0;
    if_rdata_nx   = '0;
    d_ack_nx      = 1'b0;
    d_rdata_nx    = '0;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          mem_req_nx   = 1'b1;
          mem_we_nx    = d_we;
          mem_be_nx    = d_be;
          mem_addr_nx  = d_addr;
          mem_wdata_nx = d_wdata;
          state_nx     = BUSY_D;
          if (!if_req)
            starve_cnt_nx = '0;
          else if (starve_cnt != CNT_MAX)
            starve_cnt_nx = starve_cnt + CNT_W'(1);
        end else if (if_req) begin
          mem_req_nx    = 1'b1;
          mem_we_nx     = 1'b0;
          mem_be_nx     = '1;
          mem_addr_nx   = if_addr;
          mem_wdata_nx  = '0;
          state_nx      = BUSY_IF;
          starve_cnt_nx = '0;
        end
      end
      BUSY_IF: begin
        if (mem_ready) begin
          mem_req_nx  = 1'b0;
          if_ack_nx   = 1'b1;
          if_rdata_nx = mem_rdata;
          state_nx    = DONE;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          mem_req_nx = 1'b0;
          d_ack_nx   = 1'b1;
          d_rdata_nx = mem_rdata;
          state_nx   = DONE;
        end
      end
      // Requests are ignored here so a req still high from the ack is not re-granted.
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_cnt_nx;
      mem_req    <= mem_req_nx;
      mem_we     <= mem_we_nx;
      mem_be     <= mem_be_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      if_ack     <= if_ack_nx;
      if_rdata   <= if_rdata_nx;
      d_ack      <= d_ack_nx;
      d_rdata    <= d_rdata_nx;
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of arbitration, latency and a sparse memory.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem_m [logic [31:0]];
  int busy_cycles = 0;
  int wait_n      = 0;
  bit rand_wait   = 1'b0;
  bit noise       = 1'b0;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] w;
    w = mem_rd(a);
    for (int b = 0; b < 4; b++)
      if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    mem_m[a] = w;
  endtask

  // Memory side: ready after wait_n extra cycles of mem_req; optional noise while idle.
  task automatic respond();
    if (mem_req) begin
      if (busy_cycles == wait_n) begin
        mem_ready = 1'b1;
        mem_rdata = mem_rd(mem_addr);
        if (mem_we) mem_wr(mem_addr, mem_be, mem_wdata);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      busy_cycles++;
    end else begin
      busy_cycles = 0;
      if (rand_wait) wait_n = $urandom_range(0, 3);
      mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 69'd0)
      $display("FAIL reset_mem: got %h expected 0", {mem_req, mem_we, mem_be, mem_addr, mem_wdata});
    else n_pass++;
    n_checks++;
    if ({if_ack, if_rdata} !== 33'd0) $display("FAIL reset_if: got %h expected 0", {if_ack, if_rdata});
    else n_pass++;
    n_checks++;
    if ({d_ack, d_rdata} !== 33'd0) $display("FAIL reset_d: got %h expected 0", {d_ack, d_rdata});
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_fetch();
    wait_n = 0;
    mem_m[32'h0040_0000] = 32'h2008_0005;
    if_req = 1'b1; if_addr = 32'h0040_0000;
    step();
    n_checks++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h0040_0000})
      $display("FAIL fetch_grant: got %h expected %h", {mem_req, mem_we, mem_be, mem_addr},
               {1'b1, 1'b0, 4'hF, 32'h0040_0000});
    else n_pass++;
    step();
    n_checks++;
    if ({if_ack, if_rdata, d_ack, mem_req} !== {1'b1, 32'h2008_0005, 1'b0, 1'b0})
      $display("FAIL fetch_ack: got ack=%b rdata=%h d_ack=%b mem_req=%b expected 1 20080005 0 0",
               if_ack, if_rdata, d_ack, mem_req);
    else n_pass++;
    if_req = 1'b0;
    step();
    n_checks++;
    if ({if_ack, if_rdata, mem_req} !== 34'd0)
      $display("FAIL fetch_idle: got ack=%b rdata=%h mem_req=%b expected 0", if_ack, if_rdata, mem_req);
    else n_pass++;
  endtask

  task automatic test_store_wait();
    wait_n = 2;
    mem_m[32'h1001_0004] = 32'h1122_3344;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 3; c++) begin
      step();
      n_checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_ack, if_ack} !==
          {1'b1, 1'b1, 4'b0011, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0, 1'b0})
        $display("FAIL store_hold c%0d: got req=%b we=%b be=%h addr=%h wd=%h dack=%b iack=%b", c,
                 mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_ack, if_ack);
      else n_pass++;
    end
    step();
    n_checks++;
    if ({d_ack, if_ack, mem_req} !== 3'b100)
      $display("FAIL store_ack: got d_ack=%b if_ack=%b mem_req=%b expected 1 0 0", d_ack, if_ack, mem_req);
    else n_pass++;
    d_req = 1'b0; d_we = 1'b0;
    step();
    n_checks++;
    if ({d_ack, if_ack} !== 2'b00) $display("FAIL store_ack_len: got d_ack=%b if_ack=%b expected 0 0", d_ack, if_ack);
    else n_pass++;
    n_checks++;
    if (mem_m[32'h1001_0004] !== 32'h1122_BEEF)
      $display("FAIL store_bytes: got %h expected 1122beef", mem_m[32'h1001_0004]);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    wait_n = 0;
    if_req = 1'b1; if_addr = 32'h0040_0010;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1000_0020; d_wdata = 32'h0;
    step();
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h1000_0020})
      $display("FAIL simul_data_first: got req=%b addr=%h expected 1 10000020", mem_req, mem_addr);
    else n_pass++;
    step();
    n_checks++;
    if ({d_ack, d_rdata, if_ack} !== {1'b1, mem_rd(32'h1000_0020), 1'b0})
      $display("FAIL simul_d_ack: got d_ack=%b rdata=%h if_ack=%b", d_ack, d_rdata, if_ack);
    else n_pass++;
    d_req = 1'b0;
    step();
    n_checks++;
    if (mem_req !== 1'b0) $display("FAIL simul_idle: got mem_req=%b expected 0", mem_req);
    else n_pass++;
    step();
    n_checks++;
    if ({mem_req, mem_addr, mem_we} !== {1'b1, 32'h0040_0010, 1'b0})
      $display("FAIL simul_fetch_grant: got req=%b addr=%h we=%b", mem_req, mem_addr, mem_we);
    else n_pass++;
    step();
    n_checks++;
    if ({if_ack, if_rdata} !== {1'b1, mem_rd(32'h0040_0010)})
      $display("FAIL simul_if_ack: got ack=%b rdata=%h", if_ack, if_rdata);
    else n_pass++;
    if_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic gseq [10];
    int   ng;
    logic prev;
    wait_n = 0;
    ng = 0;
    prev = mem_req;
    if_req = 1'b1; if_addr = 32'h0040_0100;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1000_0200;
    for (int c = 0; c < 30; c++) begin
      step();
      if (mem_req && !prev && ng < 10) begin
        gseq[ng] = (mem_addr == 32'h0040_0100);
        ng++;
      end
      prev = mem_req;
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int c = 0; c < 4; c++) step();
    n_checks++;
    if (ng !== 10) $display("FAIL starve_count: got %0d grants expected 10", ng);
    else n_pass++;
    for (int g = 0; g < ng; g++) begin
      n_checks++;
      if (gseq[g] !== ((g % 5) == 4))
        $display("FAIL starve_seq[%0d]: got fetch=%b expected %b", g, gseq[g], (g % 5) == 4);
      else n_pass++;
    end
  endtask

  task automatic test_held_req();
    wait_n = 1;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1000_0300;
    step();
    step();
    step();
    n_checks++;
    if (d_ack !== 1'b1) $display("FAIL held_ack: got %b expected 1", d_ack);
    else n_pass++;
    step();
    n_checks++;
    if ({mem_req, d_ack} !== 2'b00) $display("FAIL held_no_regrant: got req=%b ack=%b expected 0 0", mem_req, d_ack);
    else n_pass++;
    step();
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h1000_0300})
      $display("FAIL held_regrant: got req=%b addr=%h expected 1 10000300", mem_req, mem_addr);
    else n_pass++;
    d_req = 1'b0;
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_reset_mid();
    wait_n = 10;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1000_0400;
    step();
    step();
    rst = 1'b1; d_req = 1'b0;
    step();
    n_checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ack, if_rdata, d_ack, d_rdata} !== 135'd0)
      $display("FAIL rstmid_outputs: got req=%b addr=%h dack=%b expected all 0", mem_req, mem_addr, d_ack);
    else n_pass++;
    rst = 1'b0;
    step();
    n_checks++;
    if ({mem_req, d_ack} !== 2'b00) $display("FAIL rstmid_no_ack: got req=%b ack=%b expected 0 0", mem_req, d_ack);
    else n_pass++;
    wait_n = 0;
    mem_m[32'h0040_0200] = 32'h8C08_0000;
    if_req = 1'b1; if_addr = 32'h0040_0200;
    step();
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0040_0200})
      $display("FAIL rstmid_fetch_grant: got req=%b addr=%h", mem_req, mem_addr);
    else n_pass++;
    step();
    n_checks++;
    if ({if_ack, if_rdata} !== {1'b1, 32'h8C08_0000})
      $display("FAIL rstmid_fetch_ack: got ack=%b rdata=%h expected 1 8c080000", if_ack, if_rdata);
    else n_pass++;
    if_req = 1'b0;
    step();
  endtask

  task automatic test_random();
    int          ph;          // what the arbiter was doing last cycle: 0 idle, 1 busy, 2 done
    bit          own_d, own_st, win_d;
    int          skips;
    logic [68:0] snap;
    logic [31:0] exp_rd;
    logic [31:0] pool [8];
    for (int i = 0; i < 8; i++) pool[i] = 32'h1000_0000 + 32'(i * 4);
    rst = 1'b1; step(); rst = 1'b0;
    rand_wait = 1'b1; noise = 1'b1;
    ph = 0; skips = 0; own_d = 1'b0; own_st = 1'b0; exp_rd = '0; snap = '0;
    step();
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      case (ph)
        0: begin
          n_checks++;
          if ({if_ack, d_ack} !== 2'b00) $display("FAIL rnd_idle_ack c%0d: got %b%b expected 00", c, if_ack, d_ack);
          else n_pass++;
          if (if_req || d_req) begin
            win_d = d_req && !(if_req && skips == 4);
            if (win_d) begin
              snap = {1'b1, d_we, d_be, d_addr, d_wdata};
              skips = if_req ? ((skips < 4) ? skips + 1 : 4) : 0;
            end else begin
              snap = {1'b0, 4'hF, if_addr, 32'h0};
              skips = 0;
            end
            own_d = win_d; own_st = win_d && d_we;
            exp_rd = mem_rd(snap[63:32]);
            n_checks++;
            if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, snap})
              $display("FAIL rnd_grant c%0d: got %h expected %h", c,
                       {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, snap});
            else n_pass++;
            ph = 1;
          end else begin
            n_checks++;
            if (mem_req !== 1'b0) $display("FAIL rnd_idle_req c%0d: got %b expected 0", c, mem_req);
            else n_pass++;
          end
        end
        1: begin
          if (mem_ready) begin
            n_checks++;
            if ({mem_req, if_ack, d_ack} !== {1'b0, !own_d, own_d})
              $display("FAIL rnd_ack c%0d: got req=%b iack=%b dack=%b owner_d=%b", c, mem_req, if_ack, d_ack, own_d);
            else n_pass++;
            if (!own_st) begin
              n_checks++;
              if ((own_d ? d_rdata : if_rdata) !== exp_rd)
                $display("FAIL rnd_rdata c%0d: got %h expected %h", c, own_d ? d_rdata : if_rdata, exp_rd);
              else n_pass++;
            end
            ph = 2;
          end else begin
            n_checks++;
            if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ack, d_ack} !== {1'b1, snap, 2'b00})
              $display("FAIL rnd_hold c%0d: got %h expected %h", c,
                       {mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ack, d_ack}, {1'b1, snap, 2'b00});
            else n_pass++;
          end
        end
        default: begin
          n_checks++;
          if ({mem_req, if_ack, d_ack, if_rdata, d_rdata} !== 67'd0)
            $display("FAIL rnd_after_done c%0d: got req=%b iack=%b dack=%b ird=%h drd=%h expected 0", c,
                     mem_req, if_ack, d_ack, if_rdata, d_rdata);
          else n_pass++;
          ph = 0;
        end
      endcase
      respond();
      if (if_req ? if_ack : ($urandom_range(0, 2) == 0)) begin
        if_req = if_req ? 1'($urandom_range(0, 1)) : 1'b1;
        if_addr = pool[$urandom_range(0, 7)];
      end
      if (d_req ? d_ack : ($urandom_range(0, 1) == 0)) begin
        d_req = d_req ? 1'($urandom_range(0, 1)) : 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_be = 4'($urandom_range(0, 15));
        d_addr = pool[$urandom_range(0, 7)];
        d_wdata = $urandom;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    rand_wait = 1'b0; noise = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_single_fetch();
    test_store_wait();
    test_simultaneous();
    test_starvation();
    test_held_req();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
